// File: rtl/mul_8bit_seq_pkg.sv
// Shared constants and state encoding for the sequential shift-and-add multiplier.
package mul_8bit_seq_pkg;

  localparam int WIDTH  = 8;
  localparam int CNT_W  = 3;
  localparam int PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_8bit_seq_if.sv
// Start/busy/done request bus between a client and the multiplier.
interface mul_8bit_seq_if;

  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/mul_8bit_seq_add.sv
// 8-bit ripple-carry adder; the multiplier uses one instance for its partial-product add.
module add_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] s,
  output logic       c_out
);

  logic [8:0] carry;

  assign carry[0] = c_in;

  for (genvar gi = 0; gi < 8; gi++) begin : g_fa
    assign s[gi]       = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign c_out = carry[8];

endmodule

// File: rtl/mul_8bit_seq.sv
// Sequential 8x8 -> 16-bit unsigned multiplier: one shift-and-add step per cycle,
// eight steps per product, with a start/busy/done handshake.
module mul_8bit_seq
  import mul_8bit_seq_pkg::*;
#(
  parameter int WIDTH = mul_8bit_seq_pkg::WIDTH,
  parameter int CNT_W = mul_8bit_seq_pkg::CNT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_8bit_seq_if.slave  mul_if
);

  if (WIDTH != 8) begin : g_width_check
    $error("mul_8bit_seq: only WIDTH=8 is supported");
  end

  state_e             state_q, state_d;
  logic [7:0]         mcand_q, mcand_d;
  logic [7:0]         acc_hi_q, acc_hi_d;
  logic [7:0]         acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        product_q, product_d;

  logic [7:0]         add_b;
  logic [7:0]         add_s;
  logic               add_c;
  logic [15:0]        shifted;

  assign add_b = acc_lo_q[0] ? mcand_q : 8'h00;

  add_8bit u_add (
    .a     (acc_hi_q),
    .b     (add_b),
    .c_in  (1'b0),
    .s     (add_s),
    .c_out (add_c)
  );

  // The adder carry becomes the new top bit, so 0xFF*0xFF never loses it.
  assign shifted = {add_c, add_s, acc_lo_q[7:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      ST_IDLE: begin
        if (mul_if.start) begin
          mcand_d  = mul_if.a;
          acc_hi_d = '0;
          acc_lo_d = mul_if.b;
          cnt_d    = '0;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        {acc_hi_d, acc_lo_d} = shifted;
        if (cnt_q == {CNT_W{1'b1}}) begin
          // Product is published together with the done pulse.
          product_d = shifted;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mul_if.busy    = (state_q == ST_CALC);
  assign mul_if.done    = (state_q == ST_DONE);
  assign mul_if.product = product_q;

endmodule
